counter_sched: RTL
==================

Name: counter_sched

Overview:
- Time-shares one external 8-bit up-counter among NREQ requesters. Each requester asks for a timed interval of req_len counts.
- A round-robin arbiter grants one requester at a time. An FSM clears the counter, enables it until the terminal value, then pulses done to the winner.
- Sits between requesting control blocks and the shared counter. It drives the counter's enable/clear inputs and observes its count/overflow outputs.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CW, 8, counter width; must match the shared counter

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  NREQ  per-requester request level; held high until done or withdrawn
- req_len  input  NREQ*CW  packed terminal counts; slice i = req_len[i*CW +: CW]
- grant  output  NREQ  one-hot registered grant; all-zero when idle
- done  output  NREQ  one-cycle completion pulse, one-hot, to the granted requester
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky error flag; cleared only by reset
- cnt_en  output  1  to the counter's enable input
- cnt_clr  output  1  to the counter's clear input; clear takes effect on the clock edge where it is high
- cnt_val  input  CW  counter's current value
- cnt_ovf  input  1  counter's all-ones flag

Behaviour:
- Reset values: state=IDLE, grant=0, done=0, busy=0, err=0, cnt_en=0, cnt_clr=0, rr pointer=0, len_r=0.
- States: IDLE, CLR, RUN, DONE.
- IDLE:
  - If req!=0, pick the winner g: the first set bit of req, searching upward from the rr pointer and wrapping modulo NREQ.
  - On that cycle, register grant=onehot(g), latch len_r=req_len slice g, and move to CLR.
  - If req==0, stay in IDLE.
- CLR:
  - cnt_clr=1 for exactly one cycle, cnt_en=0.
  - Next state is RUN, with the counter at 0.
- RUN:
  - cnt_en = (cnt_val != len_r), combinational from state and cnt_val. cnt_clr=0.
  - When cnt_val==len_r, go to DONE; cnt_en is 0 that cycle, so the counter holds len_r.
  - If req[g] drops during RUN (abort), go to IDLE next cycle: grant=0, no done pulse, rr pointer = g+1 mod NREQ.
  - Abort takes priority over terminal match in the same cycle.
- DONE:
  - done[g]=1 for one cycle, grant still asserted.
  - Next state is IDLE: grant=0, rr pointer = g+1 mod NREQ.
  - The requester must drop req by the cycle after done. A req still high in IDLE is treated as a new request.
- Latency from IDLE with req high to the done pulse is len_r+3 cycles.
  - Example, len=3: c1 CLR, c2..c5 RUN (cnt 0..3), c6 DONE.
  - len=0 gives done at c3.
- len_r is fixed for the whole grant; req_len changes after latch are ignored.
- Error: err sets if cnt_ovf=1 in RUN while len_r != all-ones (the counter ran past its target). err has no other effect on the FSM.
- No wrap-around in normal use: len_r ≤ 2^CW−1, and the counter never passes len_r.
- Reset mid-operation: immediate return to reset values. The counter is not explicitly cleared; the next grant's CLR handles it.
- cnt_val is ignored in IDLE, CLR and DONE.

Test Plan:
- Single request: req=0001, len0=3, from IDLE → grant=0001 at c1, cnt_clr high c1 only, cnt_en high c2..c4, done[0] at c6, grant=0 and busy=0 at c7.
- Zero length: req=0100, len2=0 → CLR c1, RUN c2 with cnt_en=0, done[2] at c3.
- Round-robin: req=1111 held, all lengths 1, requesters re-raise after done → grant order 0,1,2,3,0; no grant ever issued twice in a row while others request.
- Abort: req=0010, len1=200, drop req[1] when cnt_val=10 → no done pulse, IDLE next cycle, cnt_en=0, next winner searched from requester 2.
- Max length: len=255 → cnt_val reaches 255, cnt_ovf=1 with err staying 0, done at cycle 258. Separately, force cnt_ovf=1 with len_r=5 during RUN → err=1 and stays 1.
- Async reset asserted mid-RUN → all outputs 0 immediately. After release, req=1000 gives grant=1000 (search starts from pointer 0).

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched: round-robin time-sharing of one external up-counter among NREQ requesters.
module counter_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] req_len,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic               err,
    output logic               cnt_en,
    output logic               cnt_clr,
    input  logic [CW-1:0]      cnt_val,
    input  logic               cnt_ovf
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
    state_t        state;
    logic [IW-1:0] rr, g_r, win;
    logic [CW-1:0] len_r;
    logic          hit;
    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NREQ);
    endfunction
    // Descending scan so the lowest offset from rr is the last assignment and wins.
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[wrap(int'(rr) + k)]) win = wrap(int'(rr) + k);
    end
    assign hit     = cnt_val == len_r;
    assign cnt_en  = state == RUN && !hit;
    assign cnt_clr = state == CLR;
    assign busy    = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            err   <= 1'b0;
            rr    <= '0;
            g_r   <= '0;
            len_r <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (|req) begin
                    state <= CLR;
                    grant <= NREQ'(1) << win;
                    g_r   <= win;
                    len_r <= req_len[int'(win)*CW +: CW];
                end
                CLR: state <= RUN;
                RUN: begin
                    if (cnt_ovf && len_r != '1) err <= 1'b1;
                    // Withdrawal beats a same-cycle terminal match.
                    if (!req[g_r]) begin
                        state <= IDLE;
                        grant <= '0;
                        rr    <= wrap(int'(g_r) + 1);
                    end else if (hit) begin
                        state <= DONE;
                        done  <= grant;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    rr    <= wrap(int'(g_r) + 1);
                end
            endcase
        end
    end
endmodule
